// File: rtl/execute_stage_if.sv
// Signal bundle between the ID/EX register, the execute stage and the memory stage.
// The execute stage uses the slave modport; its driver and consumer use the master modport.
interface execute_stage_if;
  logic        inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite;
  logic [9:0]  inPC;
  logic [31:0] inData1, inData2, signExtend;
  logic [4:0]  rt, rd;
  logic [1:0]  aluOp;
  logic        aluSrc, inRegDst;
  logic [1:0]  inForwardingA, inForwardingB;
  logic        inHazard;
  logic [31:0] outmux_WBEXE, aluResult_MEMEXE;

  logic [9:0]  outPC;
  logic        zero;
  logic [31:0] aluResult, outData2;
  logic [4:0]  wr;
  logic        outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite;
  logic [9:0]  outCurrentPC;

  modport master (
    output inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite, inPC,
           inData1, inData2, signExtend, rt, rd, aluOp, aluSrc, inRegDst,
           inForwardingA, inForwardingB, inHazard, outmux_WBEXE, aluResult_MEMEXE,
    input  outPC, zero, aluResult, outData2, wr, outBranch, outMemRead,
           outMemWrite, outMemToReg, outRegWrite, outCurrentPC
  );

  modport slave (
    input  inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite, inPC,
           inData1, inData2, signExtend, rt, rd, aluOp, aluSrc, inRegDst,
           inForwardingA, inForwardingB, inHazard, outmux_WBEXE, aluResult_MEMEXE,
    output outPC, zero, aluResult, outData2, wr, outBranch, outMemRead,
           outMemWrite, outMemToReg, outRegWrite, outCurrentPC
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage plus EX/MEM register: forwarding, ALU, branch target, destination select.
// Define EXECUTE_SHIFT_EN to build the sll/srl/sra shifter; otherwise those functs yield 0.
module execute_stage (
  input  logic             clock,
  input  logic             reset,
  execute_stage_if.slave   bus
);
  localparam logic [3:0] ALU_ZERO = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  logic [31:0] regData [2];
  logic [1:0]  fwdSel  [2];
  logic [31:0] fwdData [2];

  assign regData[0] = bus.inData1;
  assign regData[1] = bus.inData2;
  assign fwdSel[0]  = bus.inForwardingA;
  assign fwdSel[1]  = bus.inForwardingB;

  // 2'b11 deliberately falls back to the register-file value, same as 2'b00.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gFwd
      assign fwdData[gi] = (fwdSel[gi] == 2'b10) ? bus.aluResult_MEMEXE :
                           (fwdSel[gi] == 2'b01) ? bus.outmux_WBEXE : regData[gi];
    end
  endgenerate

  logic [31:0] aluA, aluB;
  logic [5:0]  funct;
  logic [3:0]  aluCtl;
  logic [31:0] aluResultNext;

  assign aluA  = fwdData[0];
  assign aluB  = bus.aluSrc ? bus.signExtend : fwdData[1];
  assign funct = bus.signExtend[5:0];

`ifdef EXECUTE_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = bus.signExtend[10:6];
`endif

  always_comb begin
    aluCtl = ALU_ZERO;
    unique case (bus.aluOp)
      2'b00: aluCtl = ALU_ADD;
      2'b01: aluCtl = ALU_SUB;
      2'b11: aluCtl = ALU_OR;
      default: begin
        case (funct)
          6'b100000: aluCtl = ALU_ADD;
          6'b100010: aluCtl = ALU_SUB;
          6'b100100: aluCtl = ALU_AND;
          6'b100101: aluCtl = ALU_OR;
          6'b100110: aluCtl = ALU_XOR;
          6'b100111: aluCtl = ALU_NOR;
          6'b101010: aluCtl = ALU_SLT;
`ifdef EXECUTE_SHIFT_EN
          6'b000000: aluCtl = ALU_SLL;
          6'b000010: aluCtl = ALU_SRL;
          6'b000011: aluCtl = ALU_SRA;
`endif
          default:   aluCtl = ALU_ZERO;
        endcase
      end
    endcase
  end

  always_comb begin
    aluResultNext = 32'd0;
    case (aluCtl)
      ALU_ADD: aluResultNext = aluA + aluB;
      ALU_SUB: aluResultNext = aluA - aluB;
      ALU_AND: aluResultNext = aluA & aluB;
      ALU_OR:  aluResultNext = aluA | aluB;
      ALU_XOR: aluResultNext = aluA ^ aluB;
      ALU_NOR: aluResultNext = ~(aluA | aluB);
      ALU_SLT: aluResultNext = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
`ifdef EXECUTE_SHIFT_EN
      ALU_SLL: aluResultNext = aluB << shamt;
      ALU_SRL: aluResultNext = aluB >> shamt;
      ALU_SRA: aluResultNext = $unsigned($signed(aluB) >>> shamt);
`endif
      default: aluResultNext = 32'd0;
    endcase
  end

  // Reset outranks the bubble; a bubble only clears the control flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.outPC        <= '0;
      bus.zero         <= 1'b0;
      bus.aluResult    <= '0;
      bus.outData2     <= '0;
      bus.wr           <= '0;
      bus.outBranch    <= 1'b0;
      bus.outMemRead   <= 1'b0;
      bus.outMemWrite  <= 1'b0;
      bus.outMemToReg  <= 1'b0;
      bus.outRegWrite  <= 1'b0;
      bus.outCurrentPC <= '0;
    end else begin
      bus.outPC        <= bus.inPC + bus.signExtend[9:0];
      bus.zero         <= (aluResultNext == 32'd0);
      bus.aluResult    <= aluResultNext;
      bus.outData2     <= fwdData[1];
      bus.wr           <= bus.inRegDst ? bus.rd : bus.rt;
      bus.outBranch    <= bus.inHazard & bus.inBranch;
      bus.outMemRead   <= bus.inHazard & bus.inMemRead;
      bus.outMemWrite  <= bus.inHazard & bus.inMemWrite;
      bus.outMemToReg  <= bus.inHazard & bus.inMemToReg;
      bus.outRegWrite  <= bus.inHazard & bus.inRegWrite;
      bus.outCurrentPC <= bus.inPC;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clock = ~clock;

  execute_stage_if exIf ();

  execute_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (exIf)
  );

  typedef struct {
    logic [4:0]  flags;   // {branch, memRead, memWrite, memToReg, regWrite}
    logic [9:0]  pc;
    logic [31:0] d1, d2, sext, wb, mem;
    logic [4:0]  rt, rd;
    logic [1:0]  aluOp, fwdA, fwdB;
    logic        aluSrc, regDst, hazard;
  } stimT;

  typedef struct {
    logic [9:0]  outPC, curPC;
    logic        zero;
    logic [31:0] alu, data2;
    logic [4:0]  wr, flags;
  } expT;

  function automatic logic [31:0] pickOperand(logic [1:0] sel, logic [31:0] regVal,
                                              logic [31:0] wb, logic [31:0] mem);
    if (sel == 2'b10) return mem;
    if (sel == 2'b01) return wb;
    return regVal;
  endfunction

  function automatic expT model(stimT s);
    expT e;
    logic [31:0] a, b, bAlu, r;
    int sh;
    a    = pickOperand(s.fwdA, s.d1, s.wb, s.mem);
    b    = pickOperand(s.fwdB, s.d2, s.wb, s.mem);
    bAlu = s.aluSrc ? s.sext : b;
    sh   = int'(s.sext[10:6]);
    r    = 32'd0;
    if (s.aluOp == 2'b00) r = a + bAlu;
    else if (s.aluOp == 2'b01) r = a - bAlu;
    else if (s.aluOp == 2'b11) r = a | bAlu;
    else begin
      case (s.sext[5:0])
        6'd32: r = a + bAlu;
        6'd34: r = a - bAlu;
        6'd36: r = a & bAlu;
        6'd37: r = a | bAlu;
        6'd38: r = a ^ bAlu;
        6'd39: r = ~(a | bAlu);
        6'd42: r = ($signed(a) < $signed(bAlu)) ? 32'd1 : 32'd0;
`ifdef EXECUTE_SHIFT_EN
        6'd0:  r = bAlu << sh;
        6'd2:  r = bAlu >> sh;
        6'd3:  r = $unsigned($signed(bAlu) >>> sh);
`endif
        default: r = 32'd0;
      endcase
    end
    e.alu   = r;
    e.zero  = (r == 0);
    e.outPC = 10'((int'(s.pc) + int'(s.sext[9:0])) % 1024);
    e.curPC = s.pc;
    e.data2 = b;
    e.wr    = s.regDst ? s.rd : s.rt;
    e.flags = s.hazard ? s.flags : 5'd0;
    return e;
  endfunction

  task automatic drive(stimT s);
    {exIf.inBranch, exIf.inMemRead, exIf.inMemWrite, exIf.inMemToReg, exIf.inRegWrite} = s.flags;
    exIf.inPC             = s.pc;
    exIf.inData1          = s.d1;
    exIf.inData2          = s.d2;
    exIf.signExtend       = s.sext;
    exIf.rt               = s.rt;
    exIf.rd               = s.rd;
    exIf.aluOp            = s.aluOp;
    exIf.aluSrc           = s.aluSrc;
    exIf.inRegDst         = s.regDst;
    exIf.inForwardingA    = s.fwdA;
    exIf.inForwardingB    = s.fwdB;
    exIf.inHazard         = s.hazard;
    exIf.outmux_WBEXE     = s.wb;
    exIf.aluResult_MEMEXE = s.mem;
  endtask

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic step(string name, stimT s, logic rst);
    expT e;
    drive(s);
    reset = rst;
    @(posedge clock);
    #1;
    if (rst) begin
      e.outPC = '0; e.curPC = '0; e.zero = 1'b0; e.alu = '0;
      e.data2 = '0; e.wr = '0; e.flags = '0;
    end else begin
      e = model(s);
    end
    check({name, ".outPC"}, 32'(exIf.outPC), 32'(e.outPC));
    check({name, ".outCurrentPC"}, 32'(exIf.outCurrentPC), 32'(e.curPC));
    check({name, ".zero"}, 32'(exIf.zero), 32'(e.zero));
    check({name, ".aluResult"}, exIf.aluResult, e.alu);
    check({name, ".outData2"}, exIf.outData2, e.data2);
    check({name, ".wr"}, 32'(exIf.wr), 32'(e.wr));
    check({name, ".flags"},
          32'({exIf.outBranch, exIf.outMemRead, exIf.outMemWrite, exIf.outMemToReg, exIf.outRegWrite}),
          32'(e.flags));
  endtask

  function automatic stimT randomStim();
    stimT s;
    logic [5:0] functs [14];
    functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
               6'd0, 6'd2, 6'd3, 6'd1, 6'd43, 6'd63, 6'd33};
    s.flags  = 5'($urandom);
    s.pc     = 10'($urandom);
    s.d1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    s.d2     = ($urandom_range(0, 3) == 0) ? s.d1 : $urandom;
    s.sext   = $urandom;
    s.sext[5:0] = functs[$urandom_range(0, 13)];
    s.wb     = $urandom;
    s.mem    = $urandom;
    s.rt     = 5'($urandom);
    s.rd     = 5'($urandom);
    s.aluOp  = 2'($urandom);
    s.fwdA   = 2'($urandom);
    s.fwdB   = 2'($urandom);
    s.aluSrc = ($urandom_range(0, 3) == 0);
    s.regDst = 1'($urandom);
    s.hazard = ($urandom_range(0, 4) != 0);
    return s;
  endfunction

  initial begin
    stimT s;
    stimT base;
    base = '{flags: 5'd0, pc: 10'd0, d1: 32'd0, d2: 32'd0, sext: 32'd0, wb: 32'd0,
             mem: 32'd0, rt: 5'd0, rd: 5'd0, aluOp: 2'd0, fwdA: 2'd0, fwdB: 2'd0,
             aluSrc: 1'b0, regDst: 1'b0, hazard: 1'b0};

    // reset with arbitrary inputs, hazard asserted valid
    s = randomStim();
    s.hazard = 1'b1;
    step("reset", s, 1'b1);

    // R-type AND
    s = base;
    s.aluOp = 2'b10; s.sext = 32'b100100; s.d1 = 1; s.d2 = 1;
    s.regDst = 1'b1; s.rd = 5'd12; s.rt = 5'd13; s.hazard = 1'b1;
    s.flags = 5'b00001;
    step("and", s, 1'b0);

    s.fwdA = 2'b10; s.mem = 4; s.wb = 3;
    step("andFwdMem", s, 1'b0);

    s.fwdA = 2'b00; s.fwdB = 2'b01;
    step("andFwdWb", s, 1'b0);

    // branch compare
    s = base;
    s.aluOp = 2'b01; s.d1 = 7; s.d2 = 7; s.pc = 10'd5; s.sext = 32'd3;
    s.flags = 5'b10000; s.hazard = 1'b1;
    step("branch", s, 1'b0);

    // branch target wraps modulo 1024
    s.pc = 10'd1020; s.sext = 32'hFFFF_FFF0;
    step("branchWrap", s, 1'b0);

    // bubble
    s = base;
    s.flags = 5'b11111; s.hazard = 1'b0; s.d1 = 32'h1234; s.d2 = 32'h10;
    step("bubble", s, 1'b0);

    // reset beats a valid instruction, next edge produces valid output again
    s.hazard = 1'b1;
    step("resetPrio", s, 1'b1);
    step("afterReset", s, 1'b0);

    // forwarding select 11 falls back to register values
    s = base;
    s.fwdA = 2'b11; s.fwdB = 2'b11; s.d1 = 32'd9; s.d2 = 32'd4;
    s.wb = 32'd100; s.mem = 32'd200; s.aluOp = 2'b01; s.hazard = 1'b1;
    step("fwd11", s, 1'b0);

    for (int i = 0; i < 400; i++) begin
      s = randomStim();
      step("random", s, ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
